// File: rtl/at_pkg.sv
// Shared definitions for the MERA-400 AT working register: mode encoding
// of the {s1,s0} select pair and the default register width.
package at_pkg;

    localparam int AT_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/ureg4_slice.sv
// 4-bit universal shift register slice equivalent to a 74194.
// Shift right moves toward q[0] and takes rsi into q[3]; shift left takes lsi into q[0].
module ureg4_slice
    import at_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s1,
    input  logic       s0,
    input  logic [3:0] d,
    input  logic       rsi,
    input  logic       lsi,
    output logic [3:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            // Unknown or undefined select values fall through to hold.
            case ({s1, s0})
                MODE_SHR:  q <= {rsi, q[3:1]};
                MODE_SHL:  q <= {q[2:0], lsi};
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/at_register.sv
// MERA-400 AT working register: WIDTH-bit universal shift register built
// from chained 4-bit 74194-style slices; at[WIDTH-1] is machine bit 0.
module at_register
    import at_pkg::*;
#(
    parameter int WIDTH = AT_WIDTH
) (
    input  logic             c,
    input  logic             _clr,
    input  logic [WIDTH-1:0] f,
    input  logic             s1,
    input  logic             s0,
    input  logic             sl,
    output logic [WIDTH-1:0] at
);

    localparam int NSLICE = WIDTH / 4;

    logic [WIDTH-1:0] q_all;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            logic rsi_w;
            logic lsi_w;

            // Right shifts pull from the slice above; the top slice takes sl.
            if (gi == NSLICE - 1) begin : g_top
                assign rsi_w = sl;
            end else begin : g_inner_r
                assign rsi_w = q_all[4*gi+4];
            end

            // Left shifts pull from the slice below; the bottom slice takes sl.
            if (gi == 0) begin : g_bottom
                assign lsi_w = sl;
            end else begin : g_inner_l
                assign lsi_w = q_all[4*gi-1];
            end

            ureg4_slice u_slice (
                .clk   (c),
                .rst_n (_clr),
                .s1    (s1),
                .s0    (s0),
                .d     (f[4*gi+3:4*gi]),
                .rsi   (rsi_w),
                .lsi   (lsi_w),
                .q     (q_all[4*gi+3:4*gi])
            );
        end
    endgenerate

    assign at = q_all;

endmodule

// File: tb/tb_at_register.sv
// Scoreboard bench for at_register: the driver pushes reference-model results,
// a monitor compares them against the register one edge later.
module tb_at_register;
    import at_pkg::*;

    logic        c    = 1'b0;
    logic        _clr = 1'b0;
    logic        s1   = 1'b0;
    logic        s0   = 1'b0;
    logic        sl   = 1'b0;
    logic [15:0] f    = '0;
    logic [15:0] at;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model  = '0;

    always #5 c = ~c;

    at_register #(.WIDTH(16)) dut (
        .c    (c),
        ._clr (_clr),
        .f    (f),
        .s1   (s1),
        .s0   (s0),
        .sl   (sl),
        .at   (at)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: at=%h expected %h", name, act, exp);
        end else begin
            $display("txn %s: at=%h ok", name, act);
        end
    endtask

    // Drive one transaction at the falling edge and queue the value the
    // register must hold after the following rising edge.
    task automatic step(input logic [1:0] m, input logic sl_v, input logic [15:0] f_v,
                        input logic clr_v, input string name);
        @(negedge c);
        _clr     = clr_v;
        {s1, s0} = m;
        sl       = sl_v;
        f        = f_v;
        if (!clr_v)
            model = 16'h0000;
        else if (m == MODE_SHR)
            model = (model >> 1) + (sl_v ? 16'h8000 : 16'h0000);
        else if (m == MODE_SHL)
            model = (model << 1) + (sl_v ? 16'h0001 : 16'h0000);
        else if (m == MODE_LOAD)
            model = f_v;
        sb_q.push_back('{model, name});
    endtask

    always @(posedge c) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, at, mon_e.exp);
        end
    end

    initial begin
        #2;
        check("reset_state", at, 16'h0000);

        step(MODE_LOAD, 1'b0, 16'hCCAA, 1'b1, "load");
        step(MODE_HOLD, 1'b0, 16'h0000, 1'b1, "hold");
        step(MODE_SHR,  1'b0, 16'h0000, 1'b1, "shr_sl0");
        step(MODE_SHR,  1'b1, 16'h0000, 1'b1, "shr_sl1");
        step(MODE_LOAD, 1'b0, 16'hCCAA, 1'b1, "reload");
        step(MODE_SHL,  1'b1, 16'h0000, 1'b1, "shl_sl1");
        step(MODE_SHL,  1'b0, 16'h0000, 1'b1, "shl_sl0");

        step(MODE_LOAD, 1'b0, 16'h0000, 1'b1, "load_zero");
        for (int i = 0; i < 17; i++)
            step(MODE_SHR, 1'b1, 16'h0000, 1'b1, (i == 16) ? "saturate_extra" : "saturate");

        // No combinational path: wiggle every input between edges.
        step(MODE_LOAD, 1'b0, 16'hA5C3, 1'b1, "load_comb");
        @(negedge c);
        for (int i = 0; i < 4; i++) begin
            f        = 16'($urandom);
            {s1, s0} = 2'($urandom);
            sl       = 1'($urandom);
            #1;
            check("no_comb", at, model);
        end
        {s1, s0} = MODE_HOLD;
        sb_q.push_back('{model, "comb_hold"});

        step(MODE_LOAD, 1'b0, 16'hFFFF, 1'b1, "load_ones");
        step(MODE_LOAD, 1'b0, 16'h1234, 1'b0, "reset_edge");
        #1;
        check("reset_async", at, 16'h0000);
        step(MODE_SHL,  1'b1, 16'h0000, 1'b0, "reset_hold");
        step(MODE_LOAD, 1'b0, 16'hBEEF, 1'b1, "after_release");

        for (int i = 0; i < 300; i++) begin
            logic [1:0]  m_r;
            logic        clr_r;
            m_r   = 2'($urandom);
            clr_r = ($urandom_range(0, 31) != 0);
            step(m_r, 1'($urandom), 16'($urandom), clr_r, "random");
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(posedge c);
        #2;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
